// File: rtl/stdcore_pkg.sv
// rtl/stdcore_pkg.sv - shared types for the stdcore SRAM streaming blocks
//
// Purpose: transfer FSM state encoding and skid-buffer sizing shared by
//          stdcore_sram_tx and stdcore_skid2.
// Ports:   none (package).

package stdcore_pkg;

  // Transfer engine states: IDLE accepts commands, RUN streams words.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

  // Skid buffer holds at most two words; occupancy counts 0..2.
  localparam int unsigned SKID_ENTRIES = 2;
  typedef logic [1:0] skid_occ_t;

  localparam skid_occ_t SKID_FULL = skid_occ_t'(SKID_ENTRIES);

endpackage

// File: rtl/stdcore_skid2.sv
// rtl/stdcore_skid2.sv - two-entry registered skid buffer
//
// Purpose: decouples the fixed-latency SRAM read path from a stalling
//          downstream consumer. The head entry is registered and drives
//          the output directly, so c never changes while c_val&!c_rdy.
// Ports:
//   clk, arst_n       clock, asynchronous active-low reset
//   clr               synchronous clear (drops all entries)
//   p, p_val, p_rdy   producer side; word enters on p_val&p_rdy
//   c, c_val, c_rdy   consumer side; word leaves on c_val&c_rdy
//   occ               current number of stored words (0..2)

module stdcore_skid2
  import stdcore_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          clr,
  input  logic [DW-1:0] p,
  input  logic          p_val,
  output logic          p_rdy,
  output logic [DW-1:0] c,
  output logic          c_val,
  input  logic          c_rdy,
  output skid_occ_t     occ
);

  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  skid_occ_t     occ_q;
  logic          push;
  logic          pop;

  // A full buffer can still take a word in the same cycle it hands one out.
  assign p_rdy = (occ_q != SKID_FULL) | c_rdy;
  assign c_val = (occ_q != 2'd0);
  assign c     = head_q;
  assign occ   = occ_q;
  assign push  = p_val & p_rdy;
  assign pop   = c_val & c_rdy;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (clr) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_q <= p;
            occ_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= p;
          end else if (push) begin
            tail_q <= p;
            occ_q  <= 2'd2;
          end else if (pop) begin
            occ_q  <= 2'd0;
          end
        end
        default: begin
          // Full: tail moves up on a pop; a simultaneous push refills it.
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= p;
            end else begin
              occ_q  <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stdcore_sram_tx.sv
// rtl/stdcore_sram_tx.sv - SRAM-to-stream transmit engine
//
// Purpose: on a command (start address, word count) reads consecutive SRAM
//          words, wrapping at DEPTH, and streams them out through a
//          two-entry skid buffer with full throughput and no loss under
//          backpressure. Pulses done for one cycle when the last word leaves.
// Ports:
//   clk                 clock
//   arst_n              asynchronous active-low reset
//   rst_n               synchronous active-low clear
//   cmd_addr, cmd_len   transfer start address and word count (0..DEPTH)
//   cmd_val, cmd_rdy    command handshake
//   raddr, re_n         SRAM read address / active-low read enable
//   rdata               SRAM read data, valid the cycle after re_n low
//   c, c_val, c_rdy     output word stream
//   done                one-cycle end-of-transfer pulse

module stdcore_sram_tx
  import stdcore_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          rst_n,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
  input  logic          cmd_val,
  output logic          cmd_rdy,
  output logic [AW-1:0] raddr,
  output logic          re_n,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] c,
  output logic          c_val,
  input  logic          c_rdy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  tx_state_t     state_q;
  tx_state_t     state_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] raddr_q;
  logic [AW:0]   remaining_q;
  logic [AW:0]   remaining_d;
  logic          inflight_q;
  logic          done_q;
  logic          done_d;
  logic          issue;
  logic          cmd_fire;
  logic          pop;
  logic          last_pop;
  logic          credit_ok;

  skid_occ_t     occ;
  logic          skid_p_rdy;
  logic          skid_c_val;

  // Everything visible is held quiet while either reset is asserted.
  assign cmd_rdy  = (state_q == ST_IDLE) & arst_n & rst_n;
  assign cmd_fire = cmd_val & cmd_rdy;
  assign c_val    = skid_c_val & rst_n;
  assign done     = done_q & rst_n;
  assign pop      = c_val & c_rdy;

  // Words already committed (buffered + read in flight) minus the one leaving
  // this cycle must leave room for another, so the skid can never overflow.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  assign last_pop = (remaining_q == '0) & ~inflight_q & (occ == 2'd1) & pop;

  assign re_n  = ~issue;
  assign raddr = issue ? addr_q : raddr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = cmd_addr;
            remaining_d = cmd_len;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        issue = rst_n & (remaining_q != '0) & credit_ok;
        if (issue) begin
          addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
        if (last_pop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      raddr_q     <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      raddr_q     <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= issue;
      done_q      <= done_d;
      if (issue) begin
        raddr_q <= addr_q;
      end
    end
  end

  // rdata belongs to the read issued last cycle; the credit rule guarantees
  // the skid has room for it.
  stdcore_skid2 #(
    .DW(DW)
  ) u_skid (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (~rst_n),
    .p      (rdata),
    .p_val  (inflight_q),
    .p_rdy  (skid_p_rdy),
    .c      (c),
    .c_val  (skid_c_val),
    .c_rdy  (c_rdy),
    .occ    (occ)
  );

  always @(posedge clk) begin
    if (arst_n && rst_n && inflight_q) begin
      assert (skid_p_rdy);
    end
  end

endmodule

// File: tb/tb_stdcore_sram_tx.sv
// tb/tb_stdcore_sram_tx.sv - scoreboard bench for stdcore_sram_tx

module tb_stdcore_sram_tx;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam logic [AW-1:0] LAST = 9'(DEPTH - 1);

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          cmd_val = 1'b0;
  logic          cmd_rdy;
  logic [AW-1:0] raddr;
  logic          re_n;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] c;
  logic          c_val;
  logic          c_rdy;
  logic          done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stdcore_sram_tx #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .rst_n    (rst_n),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_val  (cmd_val),
    .cmd_rdy  (cmd_rdy),
    .raddr    (raddr),
    .re_n     (re_n),
    .rdata    (rdata),
    .c        (c),
    .c_val    (c_val),
    .c_rdy    (c_rdy),
    .done     (done)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {7'h2B, a};
  endfunction

  // SRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (!re_n) rdata <= mem_word(raddr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  // Scoreboard
  logic [DW-1:0] exp_c[$];
  logic [AW-1:0] exp_ra[$];
  int exp_done = 0;
  int done_seen = 0;
  int pop_total = 0;
  int issued_n = 0;
  int popped_n = 0;
  int max_out = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_c = '0;

  always @(negedge clk) begin
    if (!arst_n || !rst_n) begin
      issued_n   = 0;
      popped_n   = 0;
      prev_stall = 1'b0;
    end else begin
      if (issued_n - popped_n > max_out) max_out = issued_n - popped_n;
      if (prev_stall) begin
        check("c_hold_val", 32'(c_val), 32'd1);
        check("c_hold_data", 32'(c), 32'(prev_c));
      end
      if (!re_n) begin
        issued_n++;
        if (exp_ra.size() == 0) fail_now("raddr_extra", 32'(raddr));
        else check("raddr", 32'(raddr), 32'(exp_ra.pop_front()));
      end
      if (c_val && c_rdy) begin
        popped_n++;
        pop_total++;
        if (exp_c.size() == 0) fail_now("c_extra", 32'(c));
        else check("c_data", 32'(c), 32'(exp_c.pop_front()));
      end
      if (done) done_seen++;
      prev_stall = c_val && !c_rdy;
      prev_c     = c;
    end
  end

  // Output ready driver: mode 0 holds ready high, mode 1 repeats 1,0,0,1.
  int rdy_mode = 0;
  int pat_idx = 0;
  initial begin
    c_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        c_rdy = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end else begin
        c_rdy = 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] l, output int hs);
    int n;
    logic [AW-1:0] x;
    n  = 0;
    hs = -1;
    @(posedge clk);
    #1;
    cmd_addr = a;
    cmd_len  = l;
    cmd_val  = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      if (cmd_rdy) break;
      n++;
    end
    if (!cmd_rdy) begin
      fail_now("cmd_accept_timeout", 32'(n));
    end else begin
      hs = cyc;
      x  = a;
      for (int i = 0; i < int'(l); i++) begin
        exp_ra.push_back(x);
        exp_c.push_back(mem_word(x));
        x = (x == LAST) ? '0 : x + 9'd1;
      end
      exp_done++;
    end
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_c.size() != 0 || exp_ra.size() != 0 || done_seen != exp_done) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_c.size() + exp_ra.size()), 32'd0);
    check({name, "_done_cnt"}, 32'(done_seen), 32'(exp_done));
  endtask

  task automatic flush_expect();
    exp_c.delete();
    exp_ra.delete();
    exp_done--;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int hs;
    int hs2;
    int rel;
    int base;
    int n;
    int done_before;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_c_val", 32'(c_val), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_re_n", 32'(re_n), 32'd1);
    check("rst_raddr", 32'(raddr), 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_rdy", 32'(cmd_rdy), 32'd1);

    // addr 5, len 4: cycle-exact timing
    send_cmd(9'd5, 10'd4, hs);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rel = cyc - hs;
      check($sformatf("t035_re_n_%0d", rel), 32'(re_n), 32'((rel >= 1 && rel <= 4) ? 0 : 1));
      if (rel >= 1 && rel <= 4) check($sformatf("t035_raddr_%0d", rel), 32'(raddr), 32'(4 + rel));
      check($sformatf("t035_c_val_%0d", rel), 32'(c_val), 32'((rel >= 3 && rel <= 6) ? 1 : 0));
      check($sformatf("t035_done_%0d", rel), 32'(done), 32'((rel == 7) ? 1 : 0));
    end
    wait_idle("t035");

    // Wrap across DEPTH-1 -> 0
    send_cmd(9'd510, 10'd4, hs);
    wait_idle("t036");

    // Backpressure pattern
    max_out  = 0;
    rdy_mode = 1;
    send_cmd(9'd40, 10'd8, hs);
    wait_idle("t037");
    rdy_mode = 0;
    check("t037_max_outstanding_gt2", 32'(max_out > 2), 32'd0);

    // Zero-length command
    send_cmd(9'd77, 10'd0, hs);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rel = cyc - hs;
      check($sformatf("t038_re_n_%0d", rel), 32'(re_n), 32'd1);
      check($sformatf("t038_done_%0d", rel), 32'(done), 32'((rel == 1) ? 1 : 0));
      check($sformatf("t038_cmd_rdy_%0d", rel), 32'(cmd_rdy), 32'd1);
    end
    wait_idle("t038");

    // Asynchronous reset after 5 words
    base = pop_total;
    send_cmd(9'd300, 10'd16, hs);
    n = 0;
    while (pop_total < base + 5 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t039_words_before_reset", 32'(pop_total - base), 32'd5);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("t039_c_val", 32'(c_val), 32'd0);
    check("t039_re_n", 32'(re_n), 32'd1);
    check("t039_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("t039_done", 32'(done), 32'd0);
    flush_expect();
    done_before = done_seen;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("t039_rel_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("t039_rel_c_val", 32'(c_val), 32'd0);
    check("t039_no_done", 32'(done_seen), 32'(done_before));
    send_cmd(9'd20, 10'd3, hs);
    wait_idle("t039_after");

    // Synchronous clear mid-transfer
    base = pop_total;
    send_cmd(9'd60, 10'd10, hs);
    n = 0;
    while (pop_total < base + 4 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("sclr_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("sclr_re_n", 32'(re_n), 32'd1);
    check("sclr_c_val", 32'(c_val), 32'd0);
    flush_expect();
    done_before = done_seen;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("sclr_rel_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("sclr_rel_c_val", 32'(c_val), 32'd0);
    check("sclr_rel_c", 32'(c), 32'd0);
    check("sclr_no_done", 32'(done_seen), 32'(done_before));

    // Back-to-back commands
    done_before = done_seen;
    send_cmd(9'd100, 10'd3, hs);
    send_cmd(9'd200, 10'd2, hs2);
    check("t040_second_accept_cycle", 32'(hs2 - hs), 32'd6);
    wait_idle("t040");
    check("t040_done_pulses", 32'(done_seen - done_before), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stdcore_sram_tx.md
STDCORE_SRAM_TX -- requirements
Module: stdcore_sram_tx

Interface
REQ-001 Parameter DW, default 16: data width of SRAM word and output stream.
REQ-002 Parameter AW, default 9: SRAM address width.
REQ-003 Parameter DEPTH, default 512: SRAM word count, DEPTH <= 2**AW; addresses wrap at DEPTH.
REQ-004 clk  in  1: single clock; all logic on posedge clk.
REQ-005 arst_n  in  1: asynchronous active-low reset.
REQ-006 rst_n  in  1: synchronous active-low clear, same effect as arst_n, sampled on clk.
REQ-007 cmd_addr  in  AW: start address of transfer.
REQ-008 cmd_len  in  AW+1: word count, 0..DEPTH.
REQ-009 cmd_val  in  1: command valid.
REQ-010 cmd_rdy  out  1: command accepted when cmd_val&cmd_rdy.
REQ-011 raddr  out  AW: SRAM read address.
REQ-012 re_n  out  1: SRAM read enable, active-low.
REQ-013 rdata  in  DW: SRAM read data, valid in cycle after re_n low.
REQ-014 c  out  DW: output data.
REQ-015 c_val  out  1: output valid.
REQ-016 c_rdy  in  1: output ready; word transfers when c_val&c_rdy.
REQ-017 done  out  1: one-cycle pulse at end of transfer.

Function
REQ-018 States IDLE, RUN; cmd_rdy=1 only in IDLE.
REQ-019 IDLE, cmd handshake, cmd_len>0: latch addr, remaining=cmd_len, go RUN.
REQ-020 IDLE, cmd handshake, cmd_len==0: stay IDLE, done=1 next cycle, no reads issued.
REQ-021 RUN: issue read (re_n=0, raddr=current addr) when remaining>0 and occ + inflight - (c_val&c_rdy) < 2; occ = skid entries (0..2), inflight = read issued previous cycle (0/1).
REQ-022 Each issued read: addr = (addr==DEPTH-1) ? 0 : addr+1; remaining decrements by 1.
REQ-023 rdata of each issued read captured into 2-entry skid buffer at edge ending the cycle after issue; never dropped.
REQ-024 c/c_val driven from registered skid head; c stable while c_val&!c_rdy.
REQ-025 Latency: cmd handshake cycle 0 -> first re_n low cycle 1 -> c_val high cycle 3.
REQ-026 Throughput: with c_rdy held 1, one word per cycle after first, no bubbles.
REQ-027 c_rdy=0: at most 2 words buffered; issue stalls; resumes with no loss or duplication.
REQ-028 Last word handshake at c (remaining==0, inflight==0, occ==1, pop): done=1 next cycle, state IDLE, cmd_rdy=1 next cycle.
REQ-029 Word order on c equals SRAM address order, including across wrap DEPTH-1 -> 0.
REQ-030 re_n=1 whenever no read issued; raddr holds last value when idle.

Reset
REQ-031 arst_n low or rst_n low: state IDLE, cmd_rdy=0 during reset, cmd_rdy=1 first cycle after release; c_val=0, c=0, done=0, re_n=1, raddr=0, occ=0, inflight=0, remaining=0.
REQ-032 Reset mid-transfer: transfer abandoned, buffered words discarded, no done pulse.

Structure
REQ-033 State enum (IDLE, RUN) SHALL live in shared package stdcore_pkg.
REQ-034 2-entry skid buffer SHALL be sub-module stdcore_skid2 (DW param, p/p_val/p_rdy, c/c_val/c_rdy, occupancy out).

Verification
REQ-035 cmd addr=5 len=4, c_rdy=1: re_n low cycles 1-4 with raddr 5,6,7,8; c=M[5..8] cycles 3-6; done in cycle 7.
REQ-036 cmd addr=510 len=4 DEPTH=512: raddr 510,511,0,1; c order M[510],M[511],M[0],M[1].
REQ-037 len=8, c_rdy toggling 1,0,0,1,...: all 8 words in order, occ never exceeds 2, no duplicates.
REQ-038 len=0: no re_n low, done pulse cycle 1, cmd_rdy stays high.
REQ-039 len=16, arst_n low after 5 words: c_val=0, re_n=1 immediately, no done; new cmd after release completes correctly.
REQ-040 Back-to-back cmds len=3 then len=2: second accepted cycle after done... cmd_rdy; 5 words total in order, two done pulses.
